// File: rtl/dp_seq_if.sv
// Command channel between a command source and the dp_seq sequencer.
// One command moves on each clock edge where cmd_valid and cmd_ready are both high.
interface dp_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_srca;
  logic [1:0] cmd_srcb;
  logic [1:0] cmd_alu;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_alu,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_alu,
    output cmd_ready
  );
endinterface

// File: rtl/dp_seq.sv
// Command sequencer for the 3-bit register-file datapath: latches one command
// per handshake and drives the mux, register-file and ALU controls cycle by cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command; datapath idle, output forced to zero
// S_LOAD  | LOAD1/LOAD2/CLEAR: write in1/in2/zero into dst
// S_READ  | EXEC first cycle: read srca/srcb, ALU result on out
// S_WRITE | EXEC second cycle: write ALU result into dst
module dp_seq (
  input  logic       i_clk,
  input  logic       i_rst_n,
  dp_seq_if.slave    cmd,
  output logic [1:0] o_s1,
  output logic [1:0] o_wa,
  output logic       o_we,
  output logic [1:0] o_raa,
  output logic       o_rea,
  output logic [1:0] o_rab,
  output logic       o_reb,
  output logic [1:0] o_c,
  output logic       o_s2,
  output logic       o_res_valid,
  output logic       o_done,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_READ  = 2'b10,
    S_WRITE = 2'b11
  } state_t;

  localparam logic [1:0] OP_LOAD1 = 2'b00;
  localparam logic [1:0] OP_LOAD2 = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_EXEC  = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [1:0] r_dst;
  logic [1:0] r_srca;
  logic [1:0] r_srcb;
  logic [1:0] r_alu;
  logic       w_accept;

  assign w_accept      = cmd.cmd_valid && (r_state == S_IDLE);
  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_dst   <= 2'b00;
      r_srca  <= 2'b00;
      r_srcb  <= 2'b00;
      r_alu   <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= cmd.cmd_op;
        r_dst  <= cmd.cmd_dst;
        r_srca <= cmd.cmd_srca;
        r_srcb <= cmd.cmd_srcb;
        r_alu  <= cmd.cmd_alu;
      end
    end
  end

  // Controls depend only on state and latched fields, never on cmd_* directly.
  always_comb begin
    w_next      = r_state;
    o_s1        = 2'b00;
    o_wa        = 2'b00;
    o_we        = 1'b0;
    o_raa       = 2'b00;
    o_rea       = 1'b0;
    o_rab       = 2'b00;
    o_reb       = 1'b0;
    o_c         = 2'b00;
    o_s2        = 1'b1;
    o_res_valid = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (cmd.cmd_op == OP_EXEC) ? S_READ : S_LOAD;
      end
      S_LOAD: begin
        o_we   = 1'b1;
        o_wa   = r_dst;
        o_done = 1'b1;
        case (r_op)
          OP_LOAD1: o_s1 = 2'b00;
          OP_LOAD2: o_s1 = 2'b01;
          default:  o_s1 = 2'b10;
        endcase
        w_next = S_IDLE;
      end
      S_READ: begin
        o_rea       = 1'b1;
        o_reb       = 1'b1;
        o_raa       = r_srca;
        o_rab       = r_srcb;
        o_c         = r_alu;
        o_s2        = 1'b0;
        o_res_valid = 1'b1;
        w_next      = S_WRITE;
      end
      S_WRITE: begin
        o_rea       = 1'b1;
        o_reb       = 1'b1;
        o_raa       = r_srca;
        o_rab       = r_srcb;
        o_c         = r_alu;
        o_s1        = 2'b11;
        o_we        = 1'b1;
        o_wa        = r_dst;
        o_s2        = 1'b0;
        o_res_valid = 1'b1;
        o_done      = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_seq.sv
// Directed bench for dp_seq with a small behavioural datapath attached
// (4x3 register file, ALU: 00 add, 01 sub, 10 and, 11 xor).
module tb_dp_seq;
  logic       clk;
  logic       rst_n;
  logic [1:0] s1, wa, raa, rab, c;
  logic       we, rea, reb, s2, res_valid, done, busy;
  logic [2:0] in1, in2;
  int         checks = 0;
  int         failures = 0;

  dp_seq_if u_if ();

  dp_seq u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .cmd         (u_if),
    .o_s1        (s1),
    .o_wa        (wa),
    .o_we        (we),
    .o_raa       (raa),
    .o_rea       (rea),
    .o_rab       (rab),
    .o_reb       (reb),
    .o_c         (c),
    .o_s2        (s2),
    .o_res_valid (res_valid),
    .o_done      (done),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath driven by the sequencer's controls
  logic [2:0] rf [4] = '{default: 3'd0};
  logic [2:0] rd_a, rd_b, alu_res, dp_out, wr_data;
  always_comb begin
    rd_a = rea ? rf[raa] : 3'd0;
    rd_b = reb ? rf[rab] : 3'd0;
    case (c)
      2'b00:   alu_res = rd_a + rd_b;
      2'b01:   alu_res = rd_a - rd_b;
      2'b10:   alu_res = rd_a & rd_b;
      default: alu_res = rd_a ^ rd_b;
    endcase
    dp_out = s2 ? 3'd0 : alu_res;
    case (s1)
      2'b00:   wr_data = in1;
      2'b01:   wr_data = in2;
      2'b10:   wr_data = 3'd0;
      default: wr_data = alu_res;
    endcase
  end
  always @(posedge clk) if (we) rf[wa] <= wr_data;

  logic [17:0] ctl;
  assign ctl = {s1, wa, we, raa, rea, rab, reb, c, s2, res_valid, done, busy, u_if.cmd_ready};

  function automatic logic [17:0] ev(
    input logic [1:0] e_s1, input logic [1:0] e_wa, input logic e_we,
    input logic [1:0] e_raa, input logic e_rea, input logic [1:0] e_rab, input logic e_reb,
    input logic [1:0] e_c, input logic e_s2, input logic e_rv, input logic e_done,
    input logic e_busy, input logic e_rdy);
    return {e_s1, e_wa, e_we, e_raa, e_rea, e_rab, e_reb, e_c, e_s2, e_rv, e_done, e_busy, e_rdy};
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] alu);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_dst   = dst;
    u_if.cmd_srca  = sa;
    u_if.cmd_srcb  = sb;
    u_if.cmd_alu   = alu;
  endtask

  task automatic do_load(input string tag, input logic [1:0] op, input logic [1:0] dst,
                         input logic [2:0] exp_val);
    present(op, dst, 2'd0, 2'd0, 2'd0);
    tick();
    u_if.cmd_valid = 1'b0;
    tick();
    chk3(tag, rf[dst], exp_val);
  endtask

  logic [17:0] v_idle;

  initial begin
    v_idle = ev(2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op = 2'd0; u_if.cmd_dst = 2'd0; u_if.cmd_srca = 2'd0;
    u_if.cmd_srcb = 2'd0; u_if.cmd_alu = 2'd0;
    in1 = 3'd0; in2 = 3'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_no_clock", ctl, v_idle);
    @(negedge clk) rst_n = 1'b1;

    // LOAD1 dst=2, in1=5
    in1 = 3'b101;
    present(2'b00, 2'd2, 2'd0, 2'd0, 2'd0);
    tick();
    chk("load1_cycle", ctl, ev(2'b00, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    u_if.cmd_valid = 1'b0;
    tick();
    chk("load1_idle", ctl, v_idle);
    chk3("load1_r2", rf[2], 3'd5);

    // LOAD2 then CLEAR, both dst=1, second presented while the first is in flight
    in2 = 3'b011;
    present(2'b01, 2'd1, 2'd0, 2'd0, 2'd0);
    tick();
    chk("load2_cycle", ctl, ev(2'b01, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    present(2'b10, 2'd1, 2'd0, 2'd0, 2'd0);
    tick();
    chk("load2_idle", ctl, v_idle);
    chk3("load2_r1", rf[1], 3'd3);
    tick();
    chk("clear_cycle", ctl, ev(2'b10, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    u_if.cmd_valid = 1'b0;
    tick();
    chk("clear_idle", ctl, v_idle);
    chk3("clear_r1", rf[1], 3'd0);

    // EXEC: R0=6, R1=3, R3 = R0 & R1 = 2
    in1 = 3'd6;
    do_load("prep_r0", 2'b00, 2'd0, 3'd6);
    do_load("prep_r1", 2'b01, 2'd1, 3'd3);
    present(2'b11, 2'd3, 2'd0, 2'd1, 2'b10);
    tick();
    chk("exec_read", ctl, ev(2'b00, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    chk3("exec_read_out", dp_out, 3'd2);
    present(2'b00, 2'd2, 2'd3, 2'd2, 2'b01);
    tick();
    chk("exec_write", ctl, ev(2'b11, 2'd3, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    chk3("exec_write_out", dp_out, 3'd2);
    u_if.cmd_valid = 1'b0;
    tick();
    chk("exec_idle", ctl, v_idle);
    chk3("exec_r3", rf[3], 3'd2);
    chk3("exec_r2_untouched", rf[2], 3'd5);

    // EXEC with dst = srca = srcb = 0, R0 = 3: R0 = 3 + 3 = 6
    do_load("prep_r0_3", 2'b01, 2'd0, 3'd3);
    present(2'b11, 2'd0, 2'd0, 2'd0, 2'b00);
    tick();
    chk("alias_read", ctl, ev(2'b00, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    chk3("alias_read_out", dp_out, 3'd6);
    u_if.cmd_valid = 1'b0;
    tick();
    chk("alias_write", ctl, ev(2'b11, 2'd0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    chk3("alias_write_old", dp_out, 3'd6);
    tick();
    chk3("alias_r0", rf[0], 3'd6);

    // following EXEC sees the new R0: R2 = 6 + 3 = 1 (mod 8)
    present(2'b11, 2'd2, 2'd0, 2'd1, 2'b00);
    tick();
    chk3("follow_read_out", dp_out, 3'd1);
    u_if.cmd_valid = 1'b0;
    tick();
    tick();
    chk3("follow_r2", rf[2], 3'd1);

    // reset while in READ aborts the command
    present(2'b11, 2'd3, 2'd0, 2'd1, 2'b01);
    tick();
    u_if.cmd_valid = 1'b0;
    chk("abort_in_read", ctl, ev(2'b00, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("abort_reset_async", ctl, v_idle);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("abort_post1", ctl, v_idle);
    tick();
    chk("abort_post2", ctl, v_idle);
    chk3("abort_r3_kept", rf[3], 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
